// File: rtl/line_buffer_pkg.sv
// line_buffer_pkg
// Shared constants, the pixel type and the counter-width helper for the
// 7x7 line buffer.
//   KERNEL_SIZE : window height/width (rows per emitted column)
//   NUM_LINES   : number of stored previous rows (line FIFOs)
//   pixel_t     : default 8-bit pixel type
//   cnt_width() : bit width needed to count 0..n-1 (at least 1)
package line_buffer_pkg;

    localparam int unsigned KERNEL_SIZE = 7;
    localparam int unsigned NUM_LINES   = KERNEL_SIZE - 1;
    localparam int unsigned PIXEL_W     = 8;

    typedef logic [PIXEL_W-1:0] pixel_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_buffer_7x7_line_fifo.sv
// line_fifo
// Fixed-depth shift FIFO holding one image row. Every enabled shift pushes
// data_i in and moves all entries one step toward the tail; data_o is the
// entry pushed DEPTH shifts ago. Storage is not cleared by reset.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset (blocks shifting while low)
//   shift_en : shift strobe
//   data_i   : pixel entering the head
//   data_o   : pixel at the tail
module line_fifo
    import line_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 640,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst_n && shift_en) begin
            mem[0] <= data_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign data_o = mem[DEPTH-1];

endmodule

// File: rtl/line_buffer_7x7.sv
// line_buffer_7x7
// Raster-scan line buffer: stores the six previous rows in chained line
// FIFOs and emits one vertical 7-pixel column per accepted pixel once six
// rows are stored.
// Optional feature macro: LINE_BUFFER_7X7_SOF_EN adds sof_i, which forces
// the accompanying pixel to be position (0,0) of a new frame.
// Ports:
//   clk             : clock, rising edge
//   rst_n           : synchronous active-low reset
//   done_i          : pixel valid
//   sof_i           : start of frame (only with LINE_BUFFER_7X7_SOF_EN)
//   data_i          : input pixel, raster order
//   S1_o..S7_o      : column pixels, S1_o = row r-6 ... S7_o = row r
//   done_o          : column valid
//   progress_done_o : pulse with the frame's last column
module line_buffer_7x7
    import line_buffer_pkg::*;
#(
    parameter int unsigned COLS   = 640,
    parameter int unsigned ROWS   = 480,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              done_i,
`ifdef LINE_BUFFER_7X7_SOF_EN
    input  logic              sof_i,
`endif
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] S1_o,
    output logic [DATA_W-1:0] S2_o,
    output logic [DATA_W-1:0] S3_o,
    output logic [DATA_W-1:0] S4_o,
    output logic [DATA_W-1:0] S5_o,
    output logic [DATA_W-1:0] S6_o,
    output logic [DATA_W-1:0] S7_o,
    output logic              done_o,
    output logic              progress_done_o
);

    localparam int unsigned COL_W = cnt_width(COLS);
    localparam int unsigned ROW_W = cnt_width(ROWS);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_VALID = ROW_W'(NUM_LINES);

    logic [COL_W-1:0]  col_cnt, cur_col, col_next;
    logic [ROW_W-1:0]  row_cnt, cur_row, row_next;
    logic              at_col_end, at_row_end, row_ready;
    logic [DATA_W-1:0] tail   [NUM_LINES];
    logic [DATA_W-1:0] column [KERNEL_SIZE];

    // FIFO k is fed by the tail of FIFO k-1, so FIFO k's tail is row r-1-k.
    for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
        logic [DATA_W-1:0] fifo_in;
        if (k == 0) begin : g_head
            assign fifo_in = data_i;
        end else begin : g_link
            assign fifo_in = tail[k-1];
        end
        line_fifo #(
            .DEPTH  (COLS),
            .DATA_W (DATA_W)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .shift_en (done_i),
            .data_i   (fifo_in),
            .data_o   (tail[k])
        );
    end

    // Position of the pixel being accepted; a start-of-frame pixel is (0,0)
    // regardless of the running counters.
    always_comb begin
        cur_col = col_cnt;
        cur_row = row_cnt;
`ifdef LINE_BUFFER_7X7_SOF_EN
        if (sof_i) begin
            cur_col = '0;
            cur_row = '0;
        end
`endif
        at_col_end = (cur_col == COL_LAST);
        at_row_end = (cur_row == ROW_LAST);
        row_ready  = (cur_row >= ROW_VALID);
        col_next   = at_col_end ? '0 : cur_col + 1'b1;
        row_next   = cur_row;
        if (at_col_end) begin
            row_next = at_row_end ? '0 : cur_row + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_cnt         <= '0;
            row_cnt         <= '0;
            done_o          <= 1'b0;
            progress_done_o <= 1'b0;
            for (int unsigned k = 0; k < KERNEL_SIZE; k++) begin
                column[k] <= '0;
            end
        end else begin
            done_o          <= done_i && row_ready;
            progress_done_o <= done_i && at_col_end && at_row_end;
            if (done_i) begin
                col_cnt                 <= col_next;
                row_cnt                 <= row_next;
                column[KERNEL_SIZE-1]   <= data_i;
                for (int unsigned k = 0; k < NUM_LINES; k++) begin
                    column[NUM_LINES-1-k] <= tail[k];
                end
            end
        end
    end

    assign S1_o = column[0];
    assign S2_o = column[1];
    assign S3_o = column[2];
    assign S4_o = column[3];
    assign S5_o = column[4];
    assign S6_o = column[5];
    assign S7_o = column[6];

endmodule

// File: tb/tb_line_buffer_7x7.sv
// tb_line_buffer_7x7
// Directed checks of line_buffer_7x7: a 7x7 instance (table-driven frame,
// gapped frame, back-to-back frames, mid-frame reset, optional start of
// frame) and a 10x8 instance. Pixel value = row*16 + col + offset.
module tb_line_buffer_7x7;
    import line_buffer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       done1, done_o1, prog1;
    pixel_t     data1;
    pixel_t     s1 [7];
    logic       done2, done_o2, prog2;
    pixel_t     data2;
    pixel_t     s2 [7];
    logic [55:0] col1, col2;
`ifdef LINE_BUFFER_7X7_SOF_EN
    logic sof1;
    logic sof2;
`endif

    line_buffer_7x7 #(.COLS(7), .ROWS(7), .DATA_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .done_i(done1),
`ifdef LINE_BUFFER_7X7_SOF_EN
        .sof_i(sof1),
`endif
        .data_i(data1),
        .S1_o(s1[0]), .S2_o(s1[1]), .S3_o(s1[2]), .S4_o(s1[3]),
        .S5_o(s1[4]), .S6_o(s1[5]), .S7_o(s1[6]),
        .done_o(done_o1), .progress_done_o(prog1)
    );

    line_buffer_7x7 #(.COLS(10), .ROWS(8), .DATA_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .done_i(done2),
`ifdef LINE_BUFFER_7X7_SOF_EN
        .sof_i(sof2),
`endif
        .data_i(data2),
        .S1_o(s2[0]), .S2_o(s2[1]), .S3_o(s2[2]), .S4_o(s2[3]),
        .S5_o(s2[4]), .S6_o(s2[5]), .S7_o(s2[6]),
        .done_o(done_o2), .progress_done_o(prog2)
    );

    assign col1 = {s1[0], s1[1], s1[2], s1[3], s1[4], s1[5], s1[6]};
    assign col2 = {s2[0], s2[1], s2[2], s2[3], s2[4], s2[5], s2[6]};

    int tests = 0;
    int fails = 0;
    logic [55:0] got_q [$];
    int prog_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic pixel_t pixel(input int r, input int c, input int off);
        return 8'(r * 16 + c + off);
    endfunction

    // Expected column for the pixel at (r,c): rows r-6..r, S1 in the MSBs.
    function automatic logic [55:0] col_of(input int r, input int c, input int off);
        logic [55:0] res = '0;
        for (int k = 0; k < 7; k++) begin
            res = {res[47:0], pixel(r - 6 + k, c, off)};
        end
        return res;
    endfunction

    // Drive one cycle on dut1, sample 1 time unit after the edge and
    // collect any emitted column.
    task automatic step1(input logic d, input pixel_t px);
        done1 = d;
        data1 = px;
        @(posedge clk);
        #1;
        if (done_o1) begin
            check("done_o_follows_done_i", d, 1'b1);
            got_q.push_back(col1);
        end
        if (prog1) begin
            prog_cnt++;
            check("progress_with_done_o", done_o1, 1'b1);
        end
    endtask

    task automatic feed_frame(input int off, input int rows, input int gaps);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < 7; c++) begin
                if (gaps != 0) begin
                    for (int g = 0; g < 3; g++) begin
                        if ($urandom_range(0, 1) == 0) break;
                        step1(1'b0, pixel_t'($urandom_range(0, 255)));
                    end
                end
                step1(1'b1, pixel(r, c, off));
            end
        end
    endtask

    task automatic check_frame_cols(input string name, input int first, input int off);
        for (int c = 0; c < 7; c++) begin
            if (first + c < got_q.size()) begin
                check(name, got_q[first + c], col_of(6, c, off));
            end else begin
                check(name, 64'hDEAD, {8'h00, col_of(6, c, off)});
            end
        end
    endtask

    typedef struct {
        logic        done;
        pixel_t      data;
        logic        exp_done;
        logic        exp_prog;
        logic [55:0] exp_col;
    } vec_t;

    vec_t vecs [49];

    initial begin
        int n2, p2, p2_idx;
        logic [55:0] first2, last2;

        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < 7; c++) begin
                vecs[r*7+c].done     = 1'b1;
                vecs[r*7+c].data     = pixel(r, c, 0);
                vecs[r*7+c].exp_done = (r >= 6);
                vecs[r*7+c].exp_prog = (r == 6 && c == 6);
                vecs[r*7+c].exp_col  = (r >= 6) ? col_of(r, c, 0) : '0;
            end
        end

        rst_n = 1'b0;
        done1 = 1'b0; data1 = '0;
        done2 = 1'b0; data2 = '0;
`ifdef LINE_BUFFER_7X7_SOF_EN
        sof1 = 1'b0; sof2 = 1'b0;
`endif
        prog_cnt = 0;
        step1(1'b1, 8'hAA);
        step1(1'b0, 8'h00);
        check("reset_done_o", done_o1, 1'b0);
        check("reset_progress", prog1, 1'b0);
        check("reset_column", col1, '0);
        rst_n = 1'b1;

        // Table-driven continuous 7x7 frame
        for (int i = 0; i < 49; i++) begin
            step1(vecs[i].done, vecs[i].data);
            check("tbl_done_o", done_o1, vecs[i].exp_done);
            check("tbl_progress", prog1, vecs[i].exp_prog);
            if (vecs[i].exp_done) check("tbl_column", col1, vecs[i].exp_col);
        end
        step1(1'b0, 8'h55);
        check("idle_done_o", done_o1, 1'b0);
        check("idle_progress", prog1, 1'b0);
        check("idle_hold", col1, col_of(6, 6, 0));

        // Same frame with random gaps
        got_q.delete(); prog_cnt = 0;
        feed_frame(0, 7, 1);
        step1(1'b0, 8'h00);
        check("gap_count", got_q.size(), 7);
        check_frame_cols("gap_column", 0, 0);
        check("gap_progress", prog_cnt, 1);

        // Two frames back-to-back
        got_q.delete(); prog_cnt = 0;
        feed_frame(0, 7, 0);
        feed_frame(8, 6, 0);
        check("b2b_no_early_cols", got_q.size(), 7);
        for (int c = 0; c < 7; c++) step1(1'b1, pixel(6, c, 8));
        check("b2b_count", got_q.size(), 14);
        check_frame_cols("b2b_f1_column", 0, 0);
        check_frame_cols("b2b_f2_column", 7, 8);
        check("b2b_progress", prog_cnt, 2);

        // Reset at pixel (4,3), then a full frame
        got_q.delete(); prog_cnt = 0;
        feed_frame(0, 4, 0);
        for (int c = 0; c < 3; c++) step1(1'b1, pixel(4, c, 0));
        rst_n = 1'b0;
        step1(1'b1, pixel(4, 3, 0));
        check("midrst_done_o", done_o1, 1'b0);
        check("midrst_progress", prog1, 1'b0);
        check("midrst_column", col1, '0);
        rst_n = 1'b1;
        got_q.delete(); prog_cnt = 0;
        feed_frame(1, 7, 0);
        step1(1'b0, 8'h00);
        check("midrst_count", got_q.size(), 7);
        check_frame_cols("midrst_column_seq", 0, 1);
        check("midrst_frame_progress", prog_cnt, 1);

`ifdef LINE_BUFFER_7X7_SOF_EN
        // Start of frame at (3,2) abandons the pending frame
        got_q.delete(); prog_cnt = 0;
        feed_frame(0, 3, 0);
        step1(1'b1, pixel(3, 0, 0));
        sof1 = 1'b1;
        step1(1'b0, 8'h00);
        sof1 = 1'b0;
        step1(1'b1, pixel(3, 1, 0));
        sof1 = 1'b1;
        step1(1'b1, pixel(0, 0, 2));
        sof1 = 1'b0;
        for (int c = 1; c < 7; c++) step1(1'b1, pixel(0, c, 2));
        for (int r = 1; r < 7; r++) begin
            for (int c = 0; c < 7; c++) step1(1'b1, pixel(r, c, 2));
        end
        step1(1'b0, 8'h00);
        check("sof_count", got_q.size(), 7);
        check_frame_cols("sof_column", 0, 2);
        check("sof_progress", prog_cnt, 1);
`endif

        // 10x8 instance, continuous frame
        n2 = 0; p2 = 0; p2_idx = 0; first2 = '0; last2 = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 10; c++) begin
                done2 = 1'b1;
                data2 = pixel(r, c, 0);
                @(posedge clk);
                #1;
                if (done_o2) begin
                    n2++;
                    if (n2 == 1) first2 = col2;
                    last2 = col2;
                end
                if (prog2) begin
                    p2++;
                    p2_idx = n2;
                end
            end
        end
        done2 = 1'b0;
        check("big_count", n2, 20);
        check("big_first_column", first2, col_of(6, 0, 0));
        check("big_last_column", last2, col_of(7, 9, 0));
        check("big_progress_count", p2, 1);
        check("big_progress_position", p2_idx, 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
